// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: clears a simple dual-port BRAM after reset, then round-robin arbitrates its
// write and read ports between two clients. Optional macro BRAM_PORT_ARBITER_FWD_EN forwards collision data.
module bram_port_arbiter #(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter int unsigned            ADDR_WIDTH = 2,
   parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  c0_valid,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   output logic                  c0_ready,
   output logic                  c0_rvalid,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   input  logic                  c1_valid,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c1_ready,
   output logic                  c1_rvalid,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_w_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   output logic [ADDR_WIDTH-1:0] mem_r_addr,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   output logic                  init_done
);
   localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  w_prio, r_prio;
   logic                  rd_pend, rd_owner;
   logic                  w_req0, w_req1, r_req0, r_req1;
   logic                  w_gnt0, w_gnt1, r_gnt0, r_gnt1;
   logic [ADDR_WIDTH-1:0] w_addr_sel, r_addr_sel;
   logic [DATA_WIDTH-1:0] w_data_sel, rsp_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_START;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_START: state_next = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == LAST_ADDR) state_next = ST_RUN;
         ST_RUN:   state_next = ST_RUN;
         default:  state_next = ST_START;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               clr_cnt <= '0;
      else if (state == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
   end

   assign w_req0 = c0_valid &  c0_we;
   assign w_req1 = c1_valid &  c1_we;
   assign r_req0 = c0_valid & ~c0_we;
   assign r_req1 = c1_valid & ~c1_we;

   // A lone requester always wins; under contention the prioritised client wins.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      r_gnt0 = 1'b0;
      r_gnt1 = 1'b0;
      if (state == ST_RUN) begin
         w_gnt0 = w_req0 & (~w_req1 | ~w_prio);
         w_gnt1 = w_req1 & (~w_req0 |  w_prio);
         r_gnt0 = r_req0 & (~r_req1 | ~r_prio);
         r_gnt1 = r_req1 & (~r_req0 |  r_prio);
      end
   end

   assign w_addr_sel = w_gnt1 ? c1_addr  : c0_addr;
   assign w_data_sel = w_gnt1 ? c1_wdata : c0_wdata;
   assign r_addr_sel = r_gnt1 ? c1_addr  : (r_gnt0 ? c0_addr : '0);

   always_comb begin
      c0_ready   = 1'b0;
      c1_ready   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_w_addr = '0;
      mem_w_data = '0;
      mem_r_addr = '0;
      init_done  = 1'b0;
      case (state)
         ST_CLEAR: begin
            mem_wr_en  = 1'b1;
            mem_w_addr = clr_cnt;
            mem_w_data = INIT_VALUE;
         end
         ST_RUN: begin
            init_done  = 1'b1;
            c0_ready   = w_gnt0 | r_gnt0;
            c1_ready   = w_gnt1 | r_gnt1;
            mem_wr_en  = w_gnt0 | w_gnt1;
            mem_w_addr = w_addr_sel;
            mem_w_data = w_data_sel;
            mem_r_addr = r_addr_sel;
         end
         default: ;
      endcase
   end

   // Grant hands priority to the other client; a read grant arms the one-cycle response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_prio   <= 1'b0;
         r_prio   <= 1'b0;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         if (w_gnt0)      w_prio <= 1'b1;
         else if (w_gnt1) w_prio <= 1'b0;
         if (r_gnt0)      r_prio <= 1'b1;
         else if (r_gnt1) r_prio <= 1'b0;
         rd_pend  <= r_gnt0 | r_gnt1;
         rd_owner <= r_gnt1;
      end
   end

   assign c0_rvalid = rd_pend & ~rd_owner;
   assign c1_rvalid = rd_pend &  rd_owner;

`ifdef BRAM_PORT_ARBITER_FWD_EN
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;

   // Same-address write/read in one cycle: the response carries the new data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_hit  <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd_hit  <= (r_gnt0 | r_gnt1) & (w_gnt0 | w_gnt1) & (w_addr_sel == r_addr_sel);
         fwd_data <= w_data_sel;
      end
   end

   assign rsp_data = fwd_hit ? fwd_data : mem_r_data;
`else
   assign rsp_data = mem_r_data;
`endif

   assign c0_rdata = rsp_data;
   assign c1_rdata = rsp_data;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and randomized checks of bram_port_arbiter against a
// bench-side reference of memory contents, round-robin fairness and response timing.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam logic [DW-1:0] INIT = 8'h00;

   logic          clk = 1'b0, reset_n = 1'b0;
   logic          c0_valid = 1'b0, c0_we = 1'b0, c1_valid = 1'b0, c1_we = 1'b0;
   logic [AW-1:0] c0_addr = '0, c1_addr = '0;
   logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
   logic          c0_ready, c0_rvalid, c1_ready, c1_rvalid;
   logic [DW-1:0] c0_rdata, c1_rdata;
   logic          mem_wr_en, init_done;
   logic [AW-1:0] mem_w_addr, mem_r_addr;
   logic [DW-1:0] mem_w_data, mem_r_data;
   int unsigned   nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .c0_valid(c0_valid), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_ready(c0_ready), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_valid(c1_valid), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_ready(c1_ready), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .mem_wr_en(mem_wr_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
      .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .init_done(init_done));

   // Read-first RAM with registered read data, driven by the DUT.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_wr_en) ram[mem_w_addr] <= mem_w_data;
      mem_r_data <= ram[mem_r_addr];
   end

   // Reference: cycles since reset release decide the phase; last_w/last_r hold the last winner.
   int unsigned   since_rel;
   logic [DW-1:0] m_mem [DEPTH];
   logic          last_w, last_r, ex_rv0, ex_rv1;
   logic [DW-1:0] ex_rdata;
   logic          e_wg0, e_wg1, e_rg0, e_rg1, e_wr_en, e_ready0, e_ready1;
   logic [AW-1:0] e_waddr, e_raddr;
   logic [DW-1:0] e_wdata;

   always_comb begin
      e_wg0 = 1'b0; e_wg1 = 1'b0; e_rg0 = 1'b0; e_rg1 = 1'b0;
      e_wr_en = 1'b0; e_waddr = '0; e_wdata = '0; e_raddr = '0;
      if (since_rel >= 5) begin
         if (c0_valid && c0_we && c1_valid && c1_we) begin e_wg0 = last_w; e_wg1 = !last_w; end
         else begin e_wg0 = c0_valid && c0_we; e_wg1 = c1_valid && c1_we; end
         if (c0_valid && !c0_we && c1_valid && !c1_we) begin e_rg0 = last_r; e_rg1 = !last_r; end
         else begin e_rg0 = c0_valid && !c0_we; e_rg1 = c1_valid && !c1_we; end
         e_wr_en = e_wg0 || e_wg1;
         e_waddr = e_wg1 ? c1_addr : c0_addr;
         e_wdata = e_wg1 ? c1_wdata : c0_wdata;
         if (e_rg0) e_raddr = c0_addr;
         if (e_rg1) e_raddr = c1_addr;
      end else if (since_rel >= 1) begin
         e_wr_en = 1'b1;
         e_waddr = AW'(since_rel - 1);
         e_wdata = INIT;
      end
      e_ready0 = e_wg0 || e_rg0;
      e_ready1 = e_wg1 || e_rg1;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         since_rel <= 0; last_w <= 1'b1; last_r <= 1'b1;
         ex_rv0 <= 1'b0; ex_rv1 <= 1'b0; ex_rdata <= '0;
      end else begin
         if (since_rel < 100000) since_rel <= since_rel + 1;
         if (e_wr_en) m_mem[e_waddr] <= e_wdata;
         if (e_wg0 || e_wg1) last_w <= e_wg1;
         if (e_rg0 || e_rg1) last_r <= e_rg1;
         ex_rv0 <= e_rg0;
         ex_rv1 <= e_rg1;
         if (e_rg0 || e_rg1) begin
            ex_rdata <= m_mem[e_raddr];
`ifdef BRAM_PORT_ARBITER_FWD_EN
            if ((e_wg0 || e_wg1) && e_waddr == e_raddr) ex_rdata <= e_wdata;
`endif
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic idle;
      c0_valid = 1'b0; c1_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      c0_valid = 1'b1; c0_we = 1'b0; c1_valid = 1'b1; c1_we = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      nchk++; if (init_done !== 1'b0) begin nerr++; $display("FAIL rst init_done got=%b exp=0", init_done); end
      nchk++; if ({c0_ready, c1_ready} !== 2'b00) begin nerr++; $display("FAIL rst ready got=%b%b exp=00", c0_ready, c1_ready); end
      nchk++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin nerr++; $display("FAIL rst rvalid got=%b%b exp=00", c0_rvalid, c1_rvalid); end
      nchk++; if (mem_wr_en !== 1'b0) begin nerr++; $display("FAIL rst mem_wr_en got=%b exp=0", mem_wr_en); end
      tick();
      reset_n = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         nchk++; if (mem_wr_en !== (k >= 1 && k <= 4)) begin nerr++; $display("FAIL sweep%0d mem_wr_en got=%b", k, mem_wr_en); end
         nchk++; if (init_done !== (k == 5)) begin nerr++; $display("FAIL sweep%0d init_done got=%b", k, init_done); end
         nchk++; if ({c0_ready, c1_ready} !== 2'b00) begin nerr++; $display("FAIL sweep%0d ready got=%b%b exp=00", k, c0_ready, c1_ready); end
         if (k >= 1 && k <= 4) begin
            nchk++; if (mem_w_addr !== AW'(k - 1)) begin nerr++; $display("FAIL sweep%0d addr got=%0d exp=%0d", k, mem_w_addr, k - 1); end
            nchk++; if (mem_w_data !== INIT) begin nerr++; $display("FAIL sweep%0d data got=%h exp=%h", k, mem_w_data, INIT); end
         end
         tick();
         if (k == 4) idle();
      end
   endtask

   task automatic test_contended_writes;
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd0; c0_wdata = 8'h11;
      c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 2'd3; c1_wdata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nchk++; if ({c0_ready, c1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL cw%0d ready got=%b%b", i, c0_ready, c1_ready); end
         nchk++; if (mem_wr_en !== 1'b1) begin nerr++; $display("FAIL cw%0d mem_wr_en got=%b exp=1", i, mem_wr_en); end
         nchk++; if (mem_w_addr !== ((i % 2 == 0) ? 2'd0 : 2'd3)) begin nerr++; $display("FAIL cw%0d addr got=%0d", i, mem_w_addr); end
         nchk++; if (mem_w_data !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin nerr++; $display("FAIL cw%0d data got=%h", i, mem_w_data); end
         tick();
      end
      idle();
   endtask

   task automatic test_write_then_read;
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd1; c0_wdata = 8'hA5;
      @(negedge clk);
      nchk++; if (c0_ready !== 1'b1) begin nerr++; $display("FAIL wr c0_ready got=%b exp=1", c0_ready); end
      nchk++; if (mem_w_addr !== 2'd1) begin nerr++; $display("FAIL wr addr got=%0d exp=1", mem_w_addr); end
      tick();
      idle();
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 2'd1;
      @(negedge clk);
      nchk++; if (c1_ready !== 1'b1) begin nerr++; $display("FAIL rd c1_ready got=%b exp=1", c1_ready); end
      nchk++; if (mem_r_addr !== 2'd1) begin nerr++; $display("FAIL rd r_addr got=%0d exp=1", mem_r_addr); end
      tick();
      idle();
      @(negedge clk);
      nchk++; if ({c0_rvalid, c1_rvalid} !== 2'b01) begin nerr++; $display("FAIL rsp rvalid got=%b%b exp=01", c0_rvalid, c1_rvalid); end
      nchk++; if (c1_rdata !== 8'hA5) begin nerr++; $display("FAIL rsp c1_rdata got=%h exp=a5", c1_rdata); end
      tick();
   endtask

   task automatic test_collision;
      logic [DW-1:0] exp;
`ifdef BRAM_PORT_ARBITER_FWD_EN
      exp = 8'h3C;
`else
      exp = 8'h11;
`endif
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd2; c0_wdata = 8'h11;
      tick();
      idle();
      tick();
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd2; c0_wdata = 8'h3C;
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 2'd2;
      @(negedge clk);
      nchk++; if ({c0_ready, c1_ready} !== 2'b11) begin nerr++; $display("FAIL col ready got=%b%b exp=11", c0_ready, c1_ready); end
      tick();
      idle();
      @(negedge clk);
      nchk++; if (c1_rvalid !== 1'b1) begin nerr++; $display("FAIL col c1_rvalid got=%b exp=1", c1_rvalid); end
      nchk++; if (c1_rdata !== exp) begin nerr++; $display("FAIL col c1_rdata got=%h exp=%h", c1_rdata, exp); end
      tick();
   endtask

   task automatic test_back_to_back;
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 2'd0;
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 2'd1;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         nchk++; if (c0_ready !== (i < 6 && i % 2 == 0)) begin nerr++; $display("FAIL b2b%0d c0_ready got=%b", i, c0_ready); end
         nchk++; if (c1_ready !== (i < 6 && i % 2 == 1)) begin nerr++; $display("FAIL b2b%0d c1_ready got=%b", i, c1_ready); end
         if (i >= 1) begin
            nchk++; if ({c0_rvalid, c1_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL b2b%0d rvalid got=%b%b", i, c0_rvalid, c1_rvalid); end
            nchk++; if (c0_rdata !== ((i % 2 == 1) ? 8'h11 : 8'hA5)) begin nerr++; $display("FAIL b2b%0d rdata got=%h", i, c0_rdata); end
         end
         tick();
         if (i == 5) idle();
      end
   endtask

   task automatic test_reset_mid;
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd3; c0_wdata = 8'h5A;
      tick();
      c0_we = 1'b0; c0_addr = 2'd0;
      @(negedge clk);
      nchk++; if (c0_ready !== 1'b1) begin nerr++; $display("FAIL mid c0_ready got=%b exp=1", c0_ready); end
      tick();
      idle();
      nchk++; if (c0_rvalid !== 1'b1) begin nerr++; $display("FAIL mid pend rvalid got=%b exp=1", c0_rvalid); end
      #1 reset_n = 1'b0;
      #1;
      nchk++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin nerr++; $display("FAIL mid drop rvalid got=%b%b exp=00", c0_rvalid, c1_rvalid); end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         nchk++; if ({mem_wr_en, init_done} !== {(k >= 1 && k <= 4), (k == 5)}) begin nerr++; $display("FAIL mid sweep%0d wr_en/done got=%b%b", k, mem_wr_en, init_done); end
         tick();
      end
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 2'd1; c0_wdata = 8'h77;
      c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 2'd2; c1_wdata = 8'h88;
      @(negedge clk);
      nchk++; if ({c0_ready, c1_ready} !== 2'b10) begin nerr++; $display("FAIL mid wgrant got=%b%b exp=10", c0_ready, c1_ready); end
      tick();
      c0_we = 1'b0; c1_we = 1'b0;
      @(negedge clk);
      nchk++; if ({c0_ready, c1_ready} !== 2'b10) begin nerr++; $display("FAIL mid rgrant got=%b%b exp=10", c0_ready, c1_ready); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_random;
      logic          p0, p1, acc0, acc1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic          w0, w1;
      p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; w0 = 1'b0; w1 = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!p0 && $urandom_range(3) != 0) begin
            p0 = 1'b1; w0 = 1'($urandom_range(1)); a0 = AW'($urandom_range(3)); d0 = DW'($urandom);
         end
         if (!p1 && $urandom_range(3) != 0) begin
            p1 = 1'b1; w1 = 1'($urandom_range(1)); a1 = AW'($urandom_range(3)); d1 = DW'($urandom);
         end
         c0_valid = p0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
         c1_valid = p1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
         @(negedge clk);
         nchk++; if ({c0_ready, c1_ready} !== {e_ready0, e_ready1}) begin nerr++; $display("FAIL rnd%0d ready got=%b%b exp=%b%b", n, c0_ready, c1_ready, e_ready0, e_ready1); end
         nchk++; if (mem_wr_en !== e_wr_en) begin nerr++; $display("FAIL rnd%0d mem_wr_en got=%b exp=%b", n, mem_wr_en, e_wr_en); end
         if (e_wr_en) begin
            nchk++; if ({mem_w_addr, mem_w_data} !== {e_waddr, e_wdata}) begin nerr++; $display("FAIL rnd%0d write got=%0d/%h exp=%0d/%h", n, mem_w_addr, mem_w_data, e_waddr, e_wdata); end
         end
         nchk++; if (mem_r_addr !== e_raddr) begin nerr++; $display("FAIL rnd%0d r_addr got=%0d exp=%0d", n, mem_r_addr, e_raddr); end
         nchk++; if ({c0_rvalid, c1_rvalid} !== {ex_rv0, ex_rv1}) begin nerr++; $display("FAIL rnd%0d rvalid got=%b%b exp=%b%b", n, c0_rvalid, c1_rvalid, ex_rv0, ex_rv1); end
         if (ex_rv0) begin
            nchk++; if (c0_rdata !== ex_rdata) begin nerr++; $display("FAIL rnd%0d c0_rdata got=%h exp=%h", n, c0_rdata, ex_rdata); end
         end
         if (ex_rv1) begin
            nchk++; if (c1_rdata !== ex_rdata) begin nerr++; $display("FAIL rnd%0d c1_rdata got=%h exp=%h", n, c1_rdata, ex_rdata); end
         end
         acc0 = c0_valid && c0_ready;
         acc1 = c1_valid && c1_ready;
         tick();
         if (acc0) p0 = 1'b0;
         if (acc1) p1 = 1'b0;
      end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_contended_writes();
      test_write_then_read();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
